// File: rtl/dq_pkg.sv
// dq_pkg: shared coefficient constants and raster index type for the dequant back end.
package dq_pkg;
  localparam int COEF_W = 12;
  localparam int COEF_MAX = 2047;
  localparam int COEF_MIN = -2048;
  localparam logic [5:0] BLK_LAST = 6'd63;
  typedef logic [5:0] coef_idx_t;
endpackage

// File: rtl/dq_skid.sv
// dq_skid: 1-entry skid buffer with registered output; ready depends only on local state.
module dq_skid #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         sk_v;
  logic [W-1:0] sk_d;
  logic         acc;
  assign in_ready = ~sk_v;
  assign acc = in_valid & ~sk_v;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk_v <= 1'b0;
      sk_d <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (out_ready || !out_valid) begin
      out_valid <= sk_v | acc;
      if (sk_v) out_data <= sk_d;
      else if (acc) out_data <= in_data;
      sk_v <= 1'b0;
    end else if (acc) begin
      sk_v <= 1'b1;
      sk_d <= in_data;
    end
  end
endmodule

// File: rtl/dq_satmis.sv
// dq_satmis: saturate dequantised coefficients and apply MPEG-2 mismatch control on idx 63.
// Optional SATCNT_EN adds a per-block clip counter (sat_cnt, sat_cnt_valid).
module dq_satmis
  import dq_pkg::*;
#(
  parameter int IN_W = 24,
  parameter int OUT_W = COEF_W
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   blk_start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output coef_idx_t              out_idx,
  output logic                   out_last
`ifdef SATCNT_EN
  ,
  output logic [6:0]             sat_cnt,
  output logic                   sat_cnt_valid
`endif
);
  localparam int PW = OUT_W + 7;
  localparam logic signed [IN_W-1:0] SMAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] SMIN = ~SMAX;
  logic             rdy, sk_rdy, par, cur_p, xfer, hi, lo, s1_v, s1_l;
  coef_idx_t        cnt, cur_i, s1_i;
  logic [OUT_W-1:0] sat, fix, s1_d;
  logic [PW-1:0]    pay;
  always_comb begin
    cur_i = blk_start ? '0 : cnt;
    cur_p = ~blk_start & par;
    in_ready = rdy & sk_rdy;
    xfer = in_valid & in_ready;
    hi = in_data > SMAX;
    lo = in_data < SMIN;
    sat = hi ? {1'b0, {(OUT_W-1){1'b1}}} : lo ? {1'b1, {(OUT_W-1){1'b0}}} : in_data[OUT_W-1:0];
    fix = sat ^ {{(OUT_W-1){1'b0}}, (cur_i == BLK_LAST) & ~(cur_p ^ sat[0])};
  end
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      rdy <= 1'b0;
      cnt <= '0;
      par <= 1'b0;
      s1_v <= 1'b0;
      s1_d <= '0;
      s1_i <= '0;
      s1_l <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (xfer) begin
        cnt <= cur_i + 6'd1;
        par <= (cur_i != BLK_LAST) & (cur_p ^ sat[0]);
      end else if (blk_start) begin
        cnt <= '0;
        par <= 1'b0;
      end
      // s1 only advances when the skid can take what it currently holds
      if (in_ready) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_d <= fix;
          s1_i <= cur_i;
          s1_l <= cur_i == BLK_LAST;
        end
      end
    end
  end
  dq_skid #(.W(PW)) u_skid (
    .clk      (clk),
    .rst      (srst),
    .in_valid (s1_v & in_ready),
    .in_ready (sk_rdy),
    .in_data  ({s1_l, s1_i, s1_d}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pay)
  );
  assign {out_last, out_idx, out_data} = pay;
`ifdef SATCNT_EN
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      sat_cnt <= '0;
      sat_cnt_valid <= 1'b0;
    end else begin
      sat_cnt_valid <= xfer & (cur_i == BLK_LAST);
      if (xfer) sat_cnt <= (cur_i == '0 ? 7'd0 : sat_cnt) + {6'd0, hi | lo};
      else if (blk_start) sat_cnt <= '0;
    end
  end
`endif
endmodule

// File: tb/tb_dq_satmis.sv
// tb_dq_satmis: randomized bench against a block-level arithmetic model of saturation and mismatch.
module tb_dq_satmis;
  logic clk = 1'b0;
  logic srst, blk_start, in_valid, out_ready, in_ready, out_valid, out_last;
  logic signed [23:0] in_data;
  logic signed [11:0] out_data;
  logic [5:0] out_idx;
`ifdef SATCNT_EN
  logic [6:0] sat_cnt;
  logic sat_cnt_valid;
`endif
  dq_satmis dut (
    .clk(clk), .srst(srst), .blk_start(blk_start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
`ifdef SATCNT_EN
    , .sat_cnt(sat_cnt), .sat_cnt_valid(sat_cnt_valid)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int d; int i; bit l; int m;} beat_t;
  beat_t q[$];
  int vec = 0, errs = 0, cyc = 0;
  int m_idx = 0, m_sum = 0, m_clip = 0, pend_cnt = 0, t0 = -1;
  bit pend_sc = 0, lat_arm = 0, hold = 0;
  int h_d, h_i, h_l;
  int edges[4] = '{2047, 2048, -2048, -2049};
  task automatic chk(input string tag, input int got, input int exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int gen(input int mode, input int i);
    int r;
    if (mode == 0) return 0;
    if (mode == 1) return i == 10 ? 5 : 0;
    if (mode == 2) return i == 0 ? 100000 : i == 1 ? -100000 : 0;
    r = $urandom_range(0, 7);
    if (r == 0) return $urandom_range(2048, 5000000);
    if (r == 1) return -$urandom_range(2049, 5000000);
    if (r == 2) return edges[$urandom_range(0, 3)];
    return $urandom_range(0, 4000) - 2000;
  endfunction
  function automatic int clamp(input int d);
    return d > 2047 ? 2047 : d < -2048 ? -2048 : d;
  endfunction
  task automatic step(input bit v, input bit bs, input bit ordy, input int mode, output bit x);
    int i, d, s;
    beat_t e;
    @(negedge clk);
    cyc++;
    i = bs ? 0 : m_idx;
    d = gen(mode, i);
    in_valid = v;
    in_data = d[23:0];
    blk_start = bs;
    out_ready = ordy;
    if (hold) begin
      chk("hold_v", out_valid, 1);
      chk("hold_d", int'(out_data), h_d);
      chk("hold_i", out_idx, h_i);
      chk("hold_l", out_last, h_l);
    end
    if (lat_arm && t0 >= 0 && out_valid) begin
      chk("latency", cyc - t0, 2);
      lat_arm = 0;
    end
    if (out_valid && ordy) begin
      if (q.size() == 0) chk("spurious", 1, 0);
      else begin
        e = q.pop_front();
        chk("data", int'(out_data), e.d);
        chk("idx", out_idx, e.i);
        chk("last", out_last, e.l);
        if (e.m == 0) chk("zero_blk", int'(out_data), e.i == 63 ? 1 : 0);
        if (e.m == 1 && e.i == 63) chk("odd_63", int'(out_data), 0);
        if (e.m == 2 && e.i == 0) chk("sat_pos", int'(out_data), 2047);
        if (e.m == 2 && e.i == 1) chk("sat_neg", int'(out_data), -2048);
        if (e.m == 2 && e.i == 63) chk("sat_63", int'(out_data), 0);
      end
    end
    hold = out_valid && !ordy;
    h_d = int'(out_data);
    h_i = out_idx;
    h_l = out_last;
`ifdef SATCNT_EN
    chk("sc_valid", sat_cnt_valid, pend_sc);
    if (pend_sc) chk("sc", sat_cnt, pend_cnt);
`endif
    pend_sc = 0;
    if (bs) begin
      m_idx = 0;
      m_sum = 0;
      m_clip = 0;
    end
    x = v && in_ready;
    if (x) begin
      if (lat_arm && t0 < 0) t0 = cyc;
      if (m_idx == 0) begin
        m_sum = 0;
        m_clip = 0;
      end
      s = clamp(d);
      m_sum += s;
      m_clip += (s != d) ? 1 : 0;
      e.d = (m_idx == 63 && (m_sum & 1) == 0) ? (s ^ 1) : s;
      e.i = m_idx;
      e.l = m_idx == 63;
      e.m = mode;
      q.push_back(e);
      pend_sc = m_idx == 63;
      pend_cnt = m_clip;
      m_idx = (m_idx + 1) % 64;
    end
  endtask
  task automatic run_block(input int mode, input int n, input bit bs, input bit stall);
    int sent = 0;
    bit x;
    for (int k = 0; k < 3000 && sent < n; k++) begin
      step(stall ? ($urandom_range(0, 3) != 0) : 1'b1, bs && k == 0, stall ? 1'($urandom_range(0, 1)) : 1'b1, mode, x);
      if (x) sent++;
    end
    if (sent < n) chk("in_budget", sent, n);
  endtask
  task automatic drain(input bit stall);
    bit x;
    for (int k = 0; k < 500 && (q.size() != 0 || pend_sc); k++)
      step(1'b0, 1'b0, stall ? 1'($urandom_range(0, 1)) : 1'b1, 0, x);
    chk("drain", q.size(), 0);
  endtask
  initial begin
    bit x;
    srst = 1'b1;
    blk_start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    lat_arm = 1;
    run_block(0, 64, 1, 0);
    drain(0);
    chk("latency_seen", lat_arm, 0);
    run_block(1, 64, 1, 0);
    drain(0);
    run_block(2, 64, 1, 0);
    drain(0);
    run_block(3, 64, 1, 1);
    run_block(3, 64, 0, 1);
    run_block(3, 64, 0, 1);
    drain(1);
    run_block(1, 20, 1, 0);
    run_block(0, 64, 1, 0);
    drain(0);
    run_block(3, 20, 1, 1);
    run_block(3, 64, 1, 1);
    drain(1);
    run_block(3, 30, 1, 0);
    step(1'b1, 1'b0, 1'b0, 3, x);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", out_valid, 1);
    srst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    q.delete();
    m_idx = 0;
    m_sum = 0;
    m_clip = 0;
    hold = 0;
    pend_sc = 0;
    @(negedge clk);
    srst = 1'b0;
    run_block(0, 64, 0, 0);
    drain(0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/dq_satmis.md
Name: dq_satmis

Overview:
- Stage directly downstream of the dequantiser, upstream of the IDCT.
- Takes dequantised coefficients in raster (u,v) order, 64 per block.
- Saturates each coefficient to 12-bit signed.
- Applies MPEG-2 mismatch control to coefficient 63.
- Streams the result to the IDCT over a valid/ready handshake with a skid buffer.

Parameters:
- IN_W, 24, signed input coefficient width (unsaturated dequant product).
- OUT_W, 12, signed output width; saturation bounds are -2^(OUT_W-1) .. 2^(OUT_W-1)-1.

Ports:
- clk  in  1  clock.
- srst  in  1  reset; asynchronous, active-high.
- blk_start  in  1  pulse; starts a new block and clears the index counter and parity.
- in_valid  in  1  coefficient present.
- in_ready  out  1  stage can accept a coefficient.
- in_data  in  IN_W  signed dequantised coefficient.
- out_valid  out  1  output coefficient present.
- out_ready  in  1  IDCT accepts the output.
- out_data  out  OUT_W  saturated / mismatch-corrected coefficient.
- out_idx  out  6  raster index {v[2:0],u[2:0]} of out_data.
- out_last  out  1  high with idx 63.

Behaviour:
- Reset values: in_ready=0 during reset, 1 after. out_valid=0, out_data=0, out_idx=0, out_last=0. Index counter=0, parity=0, skid empty.
- Input transfer: in_valid & in_ready on a rising clk.
- Index counter: 6 bits, increments on each input transfer and wraps 63->0.
  - At wrap, parity clears for the next block.
  - blk_start sets counter=0 and parity=0. If a transfer occurs in the same cycle, that beat is index 0.
  - A partial block abandoned by blk_start is not padded. Beats already in the pipe drain unchanged.
- Stage 1, registered:
  - sat = in_data > 2047 ? 2047 : in_data < -2048 ? -2048 : in_data[OUT_W-1:0].
  - The index is captured with the data.
  - parity ^= sat[0] for idx 0..62.
- Mismatch at idx 63:
  - total = parity ^ sat[0].
  - If total==0 (sum even), the output LSB is inverted. This gives 2047->2046, -2048->-2047, 0->1, -3->-4.
  - Otherwise the value passes unchanged.
- Stage 2: output register; out_last = (idx==63).
- Latency: 2 clk from input transfer to out_valid, with out_ready held high.
- Throughput: 1 coefficient/clk.
- Back-pressure:
  - in_ready = skid buffer empty. The skid holds 1 entry so no beat is lost when out_ready drops.
  - The output register updates only when it is empty or out_ready=1.
  - Beats are never dropped or duplicated.
  - Output data, index and last stay stable while out_valid & !out_ready.
- Simultaneous events:
  - srst overrides everything.
  - blk_start with a stalled output affects only the input-side counter and parity; queued beats keep their captured idx.
- srst mid-block: the pipe, skid, counter and parity are all cleared. No partial output follows.

Optional Feature:
- Macro SATCNT_EN.
- When defined, adds two ports:
  - sat_cnt  out  7, the number of coefficients clipped in the current block. It is cleared at blk_start and at the idx 0 beat.
  - sat_cnt_valid  out  1, a one-clk pulse when the idx 63 beat is accepted by stage 1.
- Both are reset to 0.
- When undefined, neither port exists and there is no counter logic.

Decomposition:
- Shared package dq_pkg:
  - COEF_W=12, COEF_MAX=2047, COEF_MIN=-2048, BLK_LAST=6'd63.
  - Raster index typedef coef_idx_t (6 bits).
- One natural sub-module: dq_skid, a 1-entry skid buffer, parameterised by payload width and carrying {last,idx,data}. Saturation and mismatch stay in the top level.

Test Plan:
- 64 beats of in_data=0 with out_ready=1 -> idx0..62 output 0; idx63 output 1 (even sum); out_last only at idx63; first out_valid 2 clk after the first transfer.
- Beats 0..63 are all 0 except in_data=5 at idx10 -> idx63 outputs 0 (odd sum, unchanged).
- in_data=+100000 at idx0 and -100000 at idx1, rest 0 -> outputs 2047 and -2048. Parity is odd, so idx63=0. With SATCNT_EN: sat_cnt=2 with the pulse.
- out_ready toggled 1/0 pseudo-randomly over 3 blocks -> the output sequence equals the reference model exactly, data is stable during stalls, and there is no loss or duplication.
- blk_start asserted after 20 beats, then a full new block -> the new block indices restart at 0 and its idx63 mismatch uses only new-block parity.
- srst asserted asynchronously mid-block with out_valid=1 -> out_valid drops immediately to 0, and the next block starts at idx 0 with parity 0.
